// File: rtl/if_id_stage_pkg.sv
// Shared constants for the IF/ID stage: NOP word, FSM encoding, MIPS register field positions.
package if_id_stage_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int REG_W  = RS_MSB - RS_LSB + 1;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use compare: the instruction in EX is a load whose destination feeds the one in ID.
module hazard_detect
   import if_id_stage_pkg::*;
(
   input  logic             valid_i,
   input  logic [REG_W-1:0] rs_i,
   input  logic [REG_W-1:0] rt_i,
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   output logic             load_use_o
);

   // $0 is hard-wired, so a load targeting it never creates a dependency
   assign load_use_o = valid_i & ex_mem_read_i & (ex_rt_i != '0) &
                       ((ex_rt_i == rs_i) | (ex_rt_i == rt_i));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall FSM, branch/jump flush and saturating counters.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int                 DATA_W    = 32,
   parameter int                 CNT_W     = 16,
   parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_WORD)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pc_incr,
   input  logic [DATA_W-1:0] instr,
   input  logic              ID_EX_MemRead,
   input  logic [4:0]        ID_EX_rt,
   input  logic              flush,
   output logic [DATA_W-1:0] IF_ID_pc_incr,
   output logic [DATA_W-1:0] IF_ID_instr,
   output logic              IF_ID_valid,
   output logic              PCWrite,
   output logic              ctrl_bubble,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              stall_inc, flush_inc;
   logic              load_use;

   hazard_detect u_hazard (
      .valid_i       (valid_q),
      .rs_i          (instr_q[RS_MSB:RS_LSB]),
      .rt_i          (instr_q[RT_MSB:RT_LSB]),
      .ex_mem_read_i (ID_EX_MemRead),
      .ex_rt_i       (ID_EX_rt),
      .load_use_o    (load_use)
   );

   always_comb begin
      state_d     = RUN;
      pc_d        = pc_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      PCWrite     = 1'b1;
      ctrl_bubble = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      if (flush) begin
         pc_d        = '0;
         instr_d     = NOP_INSTR;
         valid_d     = 1'b0;
         ctrl_bubble = 1'b1;
         flush_inc   = 1'b1;
      end else if (state_q == RUN && load_use) begin
         // Hold IF/ID and PC for one cycle; the load leaves EX meanwhile
         PCWrite     = 1'b0;
         ctrl_bubble = 1'b1;
         stall_inc   = 1'b1;
         state_d     = STALL;
      end else begin
         pc_d    = pc_incr;
         instr_d = instr;
         valid_d = 1'b1;
      end
      if (rst) begin
         PCWrite     = 1'b1;
         ctrl_bubble = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= '0;
         instr_q     <= NOP_INSTR;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign IF_ID_pc_incr = pc_q;
   assign IF_ID_instr   = instr_q;
   assign IF_ID_valid   = valid_q;
   assign stall_count   = stall_cnt_q;
   assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, randomized run against a reference model, counter saturation.
module tb_if_id_stage;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] pc_incr, instr;
   logic          ID_EX_MemRead;
   logic [4:0]    ID_EX_rt;
   logic          flush;
   logic [DW-1:0] IF_ID_pc_incr, IF_ID_instr;
   logic          IF_ID_valid, PCWrite, ctrl_bubble;
   logic [CW-1:0] stall_count, flush_count;

   always #5 clk = ~clk;

   if_id_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .pc_incr(pc_incr), .instr(instr),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .flush(flush),
      .IF_ID_pc_incr(IF_ID_pc_incr), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
      .PCWrite(PCWrite), .ctrl_bubble(ctrl_bubble),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change mid-cycle; outputs are sampled 1 time unit later (combinational)
   // and 1 time unit after the following rising edge (registered).
   task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] i,
                        input logic m, input logic [4:0] t, input logic f);
      @(negedge clk);
      rst = r; pc_incr = p; instr = i; ID_EX_MemRead = m; ID_EX_rt = t; flush = f;
      #1;
   endtask

   typedef struct {
      logic        r;
      logic [31:0] p, i;
      logic        m;
      logic [4:0]  t;
      logic        f;
      logic        pw, bub;
      logic [31:0] epc, eins;
      logic        ev;
      logic [15:0] esc, efc;
   } vec_t;

   vec_t tbl[20];

   // Reference model: the ID-stage contents as a plain record plus a "just stalled" flag.
   logic [31:0] m_pc, m_ins;
   logic        m_v, m_just_stalled;
   int          m_sc, m_fc;

   task automatic model_step(input logic r, input logic [31:0] p, input logic [31:0] i,
                             input logic m, input logic [4:0] t, input logic f,
                             output logic pw, output logic bub);
      int rs, rtf;
      bit hz;
      rs  = int'((m_ins >> 21) & 32'd31);
      rtf = int'((m_ins >> 16) & 32'd31);
      hz  = m_v && m && t != 0 && (int'(t) == rs || int'(t) == rtf) && !m_just_stalled;
      if (r) begin
         pw = 1; bub = 0;
         m_pc = 0; m_ins = 0; m_v = 0; m_just_stalled = 0; m_sc = 0; m_fc = 0;
      end else if (f) begin
         pw = 1; bub = 1;
         m_pc = 0; m_ins = 0; m_v = 0; m_just_stalled = 0;
         if (m_fc < 65535) m_fc++;
      end else if (hz) begin
         pw = 0; bub = 1;
         m_just_stalled = 1;
         if (m_sc < 65535) m_sc++;
      end else begin
         pw = 1; bub = 0;
         m_pc = p; m_ins = i; m_v = 1; m_just_stalled = 0;
      end
   endtask

   initial begin
      logic        epw, ebub;
      logic        r, m, f;
      logic [31:0] p, i;
      logic [4:0]  t;

      rst = 1'b1; pc_incr = '0; instr = '0; ID_EX_MemRead = 1'b0; ID_EX_rt = '0; flush = 1'b0;

      //            rst  pc_incr       instr         mr  rt  fl  pw  bub  IF_ID pc     IF_ID instr   v  stall  flush
      tbl[0]  = '{1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,        1'b0, 16'd0, 16'd0};
      tbl[1]  = '{1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,        1'b0, 16'd0, 16'd0};
      tbl[2]  = '{1'b0, 32'h4,   32'h2008_0005, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h4,  32'h2008_0005, 1'b1, 16'd0, 16'd0};
      tbl[3]  = '{1'b0, 32'h8,   32'h2009_0007, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h8,  32'h2009_0007, 1'b1, 16'd0, 16'd0};
      tbl[4]  = '{1'b0, 32'hC,   32'h0109_5020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hC,  32'h0109_5020, 1'b1, 16'd0, 16'd0};
      tbl[5]  = '{1'b0, 32'h10,  32'hAAAA_0000, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'hC,  32'h0109_5020, 1'b1, 16'd1, 16'd0};
      tbl[6]  = '{1'b0, 32'h10,  32'h0000_4020, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0000_4020, 1'b1, 16'd1, 16'd0};
      tbl[7]  = '{1'b0, 32'h14,  32'h8D09_0000, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h14, 32'h8D09_0000, 1'b1, 16'd1, 16'd0};
      tbl[8]  = '{1'b0, 32'h18,  32'h1234_5678, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 32'h0,  32'h0,        1'b0, 16'd1, 16'd1};
      tbl[9]  = '{1'b0, 32'h1C,  32'h0109_5020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h1C, 32'h0109_5020, 1'b1, 16'd1, 16'd1};
      tbl[10] = '{1'b0, 32'h20,  32'h1111_1111, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 32'h1C, 32'h0109_5020, 1'b1, 16'd2, 16'd1};
      tbl[11] = '{1'b0, 32'h20,  32'h2222_2222, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h0,  32'h0,        1'b0, 16'd2, 16'd2};
      tbl[12] = '{1'b0, 32'h24,  32'h0109_5020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0109_5020, 1'b1, 16'd2, 16'd2};
      tbl[13] = '{1'b0, 32'h28,  32'h3333_3333, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h24, 32'h0109_5020, 1'b1, 16'd3, 16'd2};
      tbl[14] = '{1'b0, 32'h28,  32'h0109_5020, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h28, 32'h0109_5020, 1'b1, 16'd3, 16'd2};
      tbl[15] = '{1'b0, 32'h2C,  32'h4444_4444, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h28, 32'h0109_5020, 1'b1, 16'd4, 16'd2};
      tbl[16] = '{1'b0, 32'h2C,  32'h0109_5020, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h2C, 32'h0109_5020, 1'b1, 16'd4, 16'd2};
      tbl[17] = '{1'b0, 32'h30,  32'h5555_5555, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h2C, 32'h0109_5020, 1'b1, 16'd5, 16'd2};
      tbl[18] = '{1'b1, 32'h30,  32'h5555_5555, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,        1'b0, 16'd0, 16'd0};
      tbl[19] = '{1'b0, 32'h34,  32'h0109_5020, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h34, 32'h0109_5020, 1'b1, 16'd0, 16'd0};

      for (int k = 0; k < 20; k++) begin
         drive(tbl[k].r, tbl[k].p, tbl[k].i, tbl[k].m, tbl[k].t, tbl[k].f);
         chk($sformatf("vec%0d PCWrite", k), 32'(PCWrite), 32'(tbl[k].pw));
         chk($sformatf("vec%0d ctrl_bubble", k), 32'(ctrl_bubble), 32'(tbl[k].bub));
         @(posedge clk); #1;
         chk($sformatf("vec%0d IF_ID_pc_incr", k), IF_ID_pc_incr, tbl[k].epc);
         chk($sformatf("vec%0d IF_ID_instr", k), IF_ID_instr, tbl[k].eins);
         chk($sformatf("vec%0d IF_ID_valid", k), 32'(IF_ID_valid), 32'(tbl[k].ev));
         chk($sformatf("vec%0d stall_count", k), 32'(stall_count), 32'(tbl[k].esc));
         chk($sformatf("vec%0d flush_count", k), 32'(flush_count), 32'(tbl[k].efc));
      end

      // Randomized run; small register numbers make dependencies frequent.
      m_pc = 0; m_ins = 0; m_v = 0; m_just_stalled = 0; m_sc = 0; m_fc = 0;
      for (int n = 0; n < 1500; n++) begin
         r = (n == 0) || ($urandom_range(0, 59) == 0);
         p = $urandom;
         i = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
         m = ($urandom_range(0, 2) != 0);
         t = 5'($urandom_range(0, 3));
         f = ($urandom_range(0, 7) == 0);
         drive(r, p, i, m, t, f);
         model_step(r, p, i, m, t, f, epw, ebub);
         chk("rand PCWrite", 32'(PCWrite), 32'(epw));
         chk("rand ctrl_bubble", 32'(ctrl_bubble), 32'(ebub));
         @(posedge clk); #1;
         chk("rand IF_ID_pc_incr", IF_ID_pc_incr, m_pc);
         chk("rand IF_ID_instr", IF_ID_instr, m_ins);
         chk("rand IF_ID_valid", 32'(IF_ID_valid), 32'(m_v));
         chk("rand stall_count", 32'(stall_count), 32'(m_sc));
         chk("rand flush_count", 32'(flush_count), 32'(m_fc));
      end

      // Flush counter saturation: 2^16+3 flushes after a reset.
      drive(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      @(posedge clk); #1;
      for (int n = 1; n <= 65539; n++) begin
         drive(1'b0, 32'h40, 32'h0109_5020, 1'b1, 5'd9, 1'b1);
         @(posedge clk); #1;
         if (n == 65534) chk("sat flush_count 65534", 32'(flush_count), 32'h0000_FFFE);
         if (n == 65535) chk("sat flush_count 65535", 32'(flush_count), 32'h0000_FFFF);
      end
      chk("sat flush_count held", 32'(flush_count), 32'h0000_FFFF);
      chk("sat stall_count", 32'(stall_count), 32'h0);
      chk("sat IF_ID_valid", 32'(IF_ID_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
